truth_table_sweeper: RTL and testbench
======================================

// Module: truth_table_sweeper
// PURPOSE
//  Sequencer that exhaustively sweeps the input space of a combinational N-input boolean
//  function unit (e.g. the udpY evaluator, Y = AB'D + BCD' + AC). It drives each vector,
//  waits a settle time, samples the 1-bit output, and builds the captured truth table.
//  It compares that table against a golden mask and reports pass/fail, the mismatch
//  count and the first failing vector. Sits between a control/CSR master and one function unit.
// PARAMETERS
//  N_IN           4        function input count; sweep length = 2**N_IN vectors
//  SETTLE_CYCLES  1        extra hold cycles per vector before sampling (0 allowed)
// PORTS
//  clk               in   1            single clock; all state changes on posedge clk
//  rst               in   1            synchronous, active-high reset
//  start             in   1            begin sweep; honoured only in IDLE
//  abort             in   1            cancel sweep in progress
//  golden            in   2**N_IN      expected truth table, bit i = Y(vec=i); latched on start
//  vec               out  N_IN         vector to function unit, MSB = first input (A)
//  dut_y             in   1            function unit output
//  busy              out  1            high from the cycle after start until done/abort
//  done              out  1            1-cycle pulse, sweep complete
//  pass              out  1            valid from done until next start; 1 = zero mismatches
//  mismatch_cnt      out  N_IN+1       number of vectors with dut_y != golden[vec]
//  first_fail_vec    out  N_IN         lowest failing vector index
//  first_fail_valid  out  1            first_fail_vec holds a real failure
//  result_tt         out  2**N_IN      captured truth table, bit i = sampled dut_y at vec=i
// BEHAVIOUR
//  - Reset: state IDLE; every output 0 (vec=0, busy=0, done=0, pass=0, counts/tables 0).
//  - FSM: IDLE -> DRIVE -> (SAMPLE -> DRIVE)* -> DONE -> IDLE.
//  - IDLE: on start, latch golden, clear result_tt, mismatch_cnt and first_fail_*;
//    enter DRIVE next cycle with vec=0 and settle counter = SETTLE_CYCLES.
//  - DRIVE: hold vec; decrement settle counter; at 0, go to SAMPLE.
//  - SAMPLE (1 cycle, vec still held): result_tt[vec] <= dut_y. On mismatch, increment
//    mismatch_cnt; if first_fail_valid=0, set first_fail_vec=vec and first_fail_valid=1.
//    If vec == 2**N_IN-1, go to DONE; else vec+1, reload settle counter, go to DRIVE.
//  - Each vector occupies SETTLE_CYCLES+1 cycles, sampled in its last cycle. vec never wraps.
//  - DONE: done=1 for one cycle, pass=(mismatch_cnt==0), busy=0; next cycle IDLE.
//  - Latency: start at edge t -> done high in cycle t + 2**N_IN*(SETTLE_CYCLES+1) + 1
//    (defaults: 33; SETTLE_CYCLES=0: 17).
//  - start while busy: ignored, no relatch. start coincident with done: ignored, accepted
//    from IDLE the following cycle.
//  - abort (any non-IDLE state): IDLE next cycle, no done pulse, pass=0. Partial result_tt,
//    mismatch_cnt and first_fail_* hold. abort wins over a simultaneous last SAMPLE.
//    abort in IDLE has no effect; start+abort in IDLE: abort wins, sweep not started.
//  - rst has priority over everything, mid-sweep included: back to reset values next edge.
//  - mismatch_cnt max 2**N_IN fits N_IN+1 bits; no saturation logic.
//  - dut_y X/Z in simulation counts as a mismatch (case-inequality compare).
// STRUCTURE
//  - Shared package tt_sweep_pkg: FSM state encoding (IDLE, DRIVE, SAMPLE, DONE) and
//    constant GOLDEN_UDPY = 16'hCE40, the udpY table with bit index {A,B,C,D}.
//  - One sub-module: tt_sweep_counter, holding the vec counter, settle counter, last-vector
//    flag and settle-zero flag. FSM, compare and result registers stay in the top.
// TESTING (DUT = udpY instance driven by vec, defaults)
//  1. golden=16'hCE40, start -> done at start+33, pass=1, mismatch_cnt=0, result_tt=16'hCE40.
//  2. golden=16'hCE41 -> pass=0, mismatch_cnt=1, first_fail_vec=0, first_fail_valid=1.
//  3. golden=16'h0000 -> mismatch_cnt=6, first_fail_vec=6, result_tt=16'hCE40.
//  4. abort 10 cycles after start -> no done, busy=0 next cycle, pass=0; new start -> case 1 results.
//  5. rst mid-sweep and start pulses while busy -> all outputs 0 after rst; extra starts do not
//     restart or extend the sweep.
//  6. SETTLE_CYCLES=0 build -> done at start+17; vec changes every cycle 0..15; pass=1.

Source files
------------

// File: rtl/tt_sweep_pkg.sv
// Shared definitions for the truth-table sweeper: FSM encoding and the
// reference udpY table.
package tt_sweep_pkg;

  // Sweep sequencer states. IDLE is encoding 0 so a cleared register is IDLE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // udpY truth table, Y = AB'D + BCD' + AC, bit index {A,B,C,D}.
  localparam logic [15:0] GOLDEN_UDPY = 16'hCE40;

endpackage

// File: rtl/tt_sweep_counter.sv
// Vector index and per-vector settle counter for the truth-table sweeper.
// The FSM in the top decides when to load, advance or tick; this block only
// keeps the counts and reports the two flags the FSM branches on.
module tt_sweep_counter
  import tt_sweep_pkg::*;
#(
  parameter int N_IN          = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,        // new sweep: vec=0, settle reloaded
  input  logic            advance,     // next vector: vec+1, settle reloaded
  input  logic            tick,        // one hold cycle spent in DRIVE
  output logic [N_IN-1:0] vec,
  output logic            last_vec,    // vec is the final vector of the sweep
  output logic            settle_zero  // this DRIVE cycle is the final hold cycle
);

  localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);
  localparam logic [N_IN-1:0] VEC_ONE   = N_IN'(1);

  logic [SW-1:0] settle;

  // Vector and settle counters; vec never wraps because the FSM stops advancing
  // at the last vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec    <= '0;
      settle <= '0;
    end else if (load) begin
      vec    <= '0;
      settle <= SETTLE_INIT;
    end else if (advance) begin
      vec    <= vec + VEC_ONE;
      settle <= SETTLE_INIT;
    end else if (tick && (settle != '0)) begin
      settle <= settle - SETTLE_ONE;
    end
  end

  assign last_vec    = (vec == {N_IN{1'b1}});
  assign settle_zero = (settle <= SETTLE_ONE);

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper for an N_IN-input boolean function unit.
// Drives every vector in order, holds it SETTLE_CYCLES extra cycles, samples
// dut_y in the last cycle of each vector and compares against a golden table
// latched at start.
//
// Handshake: start is a level sampled on posedge clk and is accepted only in
// IDLE with abort low; busy rises the cycle after acceptance; done is a single
// cycle pulse, after which pass/mismatch_cnt/first_fail_*/result_tt hold until
// the next accepted start. abort in DRIVE/SAMPLE/DONE returns to IDLE with no
// done pulse and leaves the partial results in place.
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int N_IN          = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [2**N_IN-1:0] golden,
  output logic [N_IN-1:0]    vec,
  input  logic               dut_y,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [N_IN:0]      mismatch_cnt,
  output logic [N_IN-1:0]    first_fail_vec,
  output logic               first_fail_valid,
  output logic [2**N_IN-1:0] result_tt,
  output state_t             dbg_state
);

  localparam int DEPTH = 2**N_IN;
  localparam logic [N_IN:0] CNT_ONE = (N_IN+1)'(1);
  // With no settle cycles a vector is a single SAMPLE cycle and DRIVE is skipped.
  localparam state_t FIRST_ST = (SETTLE_CYCLES > 0) ? ST_DRIVE : ST_SAMPLE;

  state_t           state;
  state_t           state_next;
  logic             load;
  logic             advance;
  logic             tick;
  logic             sample_en;
  logic             last_vec;
  logic             settle_zero;
  logic             mismatch;
  logic [DEPTH-1:0] golden_q;

  tt_sweep_counter #(
    .N_IN          (N_IN),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_counter (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .advance     (advance),
    .tick        (tick),
    .vec         (vec),
    .last_vec    (last_vec),
    .settle_zero (settle_zero)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state and per-cycle control; abort takes precedence in every busy state.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    tick       = 1'b0;
    sample_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          load       = 1'b1;
          state_next = FIRST_ST;
        end
      end
      ST_DRIVE: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else begin
          tick = 1'b1;
          if (settle_zero) state_next = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else begin
          sample_en = 1'b1;
          if (last_vec) begin
            state_next = ST_DONE;
          end else begin
            advance    = 1'b1;
            state_next = FIRST_ST;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Case inequality so an X/Z from the function unit is reported as a failure.
  always_comb begin
    mismatch = (dut_y !== golden_q[vec]);
  end

  // Golden latch, captured table and mismatch bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      golden_q         <= '0;
      result_tt        <= '0;
      mismatch_cnt     <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
      pass             <= 1'b0;
    end else if (load) begin
      golden_q         <= golden;
      result_tt        <= '0;
      mismatch_cnt     <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
      pass             <= 1'b0;
    end else if (sample_en) begin
      result_tt[vec] <= dut_y;
      if (mismatch) begin
        mismatch_cnt <= mismatch_cnt + CNT_ONE;
        if (!first_fail_valid) begin
          first_fail_vec   <= vec;
          first_fail_valid <= 1'b1;
        end
      end
      if (last_vec) pass <= (mismatch_cnt == '0) && !mismatch;
    end
  end

  assign busy      = (state == ST_DRIVE) || (state == ST_SAMPLE);
  assign done      = (state == ST_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper driving a behavioural udpY function unit.
module tb_truth_table_sweeper;
  import tt_sweep_pkg::*;

  localparam int EW = 35;  // {lat[7:0], pass, cnt[4:0], ffv[3:0], ffvalid, tt[15:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (default settle) ----------------
  logic        start = 1'b0, abort = 1'b0;
  logic [15:0] golden = '0;
  logic [3:0]  vec;
  logic        dut_y, busy, done, pass, first_fail_valid;
  logic [4:0]  mismatch_cnt;
  logic [3:0]  first_fail_vec;
  logic [15:0] result_tt;
  state_t      dbg_state;

  // ---------------- DUT (no settle) ----------------
  logic        start2 = 1'b0;
  logic [3:0]  vec2;
  logic        dut_y2, busy2, done2, pass2, ffvalid2;
  logic [4:0]  cnt2;
  logic [3:0]  ffv2;
  logic [15:0] tt2;
  state_t      dbg_state2;

  function automatic logic udpy(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return (a & ~b & d) | (b & c & ~d) | (a & c);
  endfunction

  assign dut_y  = udpy(vec);
  assign dut_y2 = udpy(vec2);

  truth_table_sweeper #(.N_IN(4), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .golden(golden),
    .vec(vec), .dut_y(dut_y), .busy(busy), .done(done), .pass(pass),
    .mismatch_cnt(mismatch_cnt), .first_fail_vec(first_fail_vec),
    .first_fail_valid(first_fail_valid), .result_tt(result_tt),
    .dbg_state(dbg_state)
  );

  truth_table_sweeper #(.N_IN(4), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start2), .abort(1'b0), .golden(GOLDEN_UDPY),
    .vec(vec2), .dut_y(dut_y2), .busy(busy2), .done(done2), .pass(pass2),
    .mismatch_cnt(cnt2), .first_fail_vec(ffv2),
    .first_fail_valid(ffvalid2), .result_tt(tt2),
    .dbg_state(dbg_state2)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int passes = 0;
  int start_edge = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    else passes++;
  endtask

  task automatic push_exp(input logic p, input logic [4:0] cnt, input logic [3:0] ffv,
                          input logic ffvalid, input logic [15:0] tt);
    logic [7:0] lat;
    lat = 8'd33;
    exp_q.push_back({lat, p, cnt, ffv, ffvalid, tt});
  endtask

  // Monitor: every done pulse is matched against the oldest expected sweep.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: done=1 with no sweep expected (cycle %0d)", cyc);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        chk("latency",          32'(cyc + 1 - start_edge), 32'(e[34:27]));
        chk("pass",             32'(pass),             32'(e[26]));
        chk("mismatch_cnt",     32'(mismatch_cnt),     32'(e[25:21]));
        chk("first_fail_vec",   32'(first_fail_vec),   32'(e[20:17]));
        chk("first_fail_valid", 32'(first_fail_valid), 32'(e[16]));
        chk("result_tt",        32'(result_tt),        32'(e[15:0]));
        chk("busy_at_done",     32'(busy),             32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [15:0] g);
    @(negedge clk);
    golden     = g;
    start      = 1'b1;
    start_edge = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      $display("FAIL done_timeout: no done within 100 cycles (cycle %0d)", cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_vec"},     32'(vec),              32'd0);
    chk({tag, "_busy"},    32'(busy),             32'd0);
    chk({tag, "_done"},    32'(done),             32'd0);
    chk({tag, "_pass"},    32'(pass),             32'd0);
    chk({tag, "_cnt"},     32'(mismatch_cnt),     32'd0);
    chk({tag, "_ffv"},     32'(first_fail_vec),   32'd0);
    chk({tag, "_ffvalid"}, 32'(first_fail_valid), 32'd0);
    chk({tag, "_tt"},      32'(result_tt),        32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset");

    // Matching golden: clean pass; busy rises the cycle after start.
    push_exp(1'b1, 5'd0, 4'd0, 1'b0, 16'hCE40);
    do_start(GOLDEN_UDPY);
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_done();

    // Single wrong bit at vector 0.
    push_exp(1'b0, 5'd1, 4'd0, 1'b1, 16'hCE40);
    do_start(16'hCE41);
    wait_done();

    // All-zero golden: every true row of udpY fails, lowest is 6.
    push_exp(1'b0, 5'd6, 4'd6, 1'b1, 16'hCE40);
    do_start(16'h0000);
    wait_done();

    // Abort sampled at start edge + 10.
    do_start(GOLDEN_UDPY);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy",  32'(busy),             32'd0);
    chk("abort_pass",  32'(pass),             32'd0);
    chk("abort_done",  32'(done),             32'd0);
    chk("abort_state", 32'(dbg_state),        32'(ST_IDLE));
    chk("abort_cnt",   32'(mismatch_cnt),     32'd0);
    chk("abort_tt",    32'(result_tt),        32'd0);
    repeat (30) @(negedge clk);

    push_exp(1'b1, 5'd0, 4'd0, 1'b0, 16'hCE40);
    do_start(GOLDEN_UDPY);
    wait_done();

    // Abort coinciding with the final SAMPLE: vector 15 is not recorded.
    do_start(16'h0000);
    repeat (31) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_last_busy", 32'(busy),           32'd0);
    chk("abort_last_tt",   32'(result_tt),      32'h4E40);
    chk("abort_last_cnt",  32'(mismatch_cnt),   32'd5);
    chk("abort_last_ffv",  32'(first_fail_vec), 32'd6);
    chk("abort_last_pass", 32'(pass),           32'd0);
    repeat (5) @(negedge clk);

    // Reset in the middle of a sweep.
    do_start(16'h0000);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("midrst");
    chk("midrst_state", 32'(dbg_state), 32'(ST_IDLE));

    // Extra starts while busy must neither relatch golden nor restart.
    push_exp(1'b0, 5'd1, 4'd0, 1'b1, 16'hCE40);
    do_start(16'hCE41);
    for (int i = 0; i < 3; i++) begin
      repeat (5) @(negedge clk);
      golden = 16'h0000;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
    end
    wait_done();
    // Start held during the done cycle is ignored.
    golden = GOLDEN_UDPY;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    chk("start_at_done_busy",  32'(busy),      32'd0);
    chk("start_at_done_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    chk("start_at_done_idle",  32'(busy),      32'd0);
    repeat (40) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // No-settle build: one vector per cycle, done 17 cycles after start.
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("s0_vec%0d", k), 32'(vec2), 32'(k));
      chk($sformatf("s0_nodone%0d", k), 32'(done2), 32'd0);
      @(negedge clk);
    end
    chk("s0_done",  32'(done2), 32'd1);
    chk("s0_pass",  32'(pass2), 32'd1);
    chk("s0_cnt",   32'(cnt2),  32'd0);
    chk("s0_tt",    32'(tt2),   32'hCE40);
    @(negedge clk);
    chk("s0_done_pulse", 32'(done2), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
